// File: rtl/fir_sample_feeder.sv
// Feeds a serial FIR filter one sample at a time from a small FIFO, waits for its
// output strobe (with a watchdog), and hands each result out on a valid/ready port.
module fir_sample_feeder #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255,
    localparam int OUT_W  = 2 * WIDTH + 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] fir_sample,
    output logic                    fir_valid,
    input  logic signed [OUT_W-1:0] fir_result,
    input  logic                    fir_result_valid,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    timeout_err,
    input  logic                    err_clr,
    output logic [15:0]             sample_count,
    output logic [1:0]              state_dbg
);
    // Handshakes: a word moves on s_valid && s_ready (upstream) and on
    // m_valid && m_ready (downstream); once raised, m_valid and m_data stay
    // unchanged until the transfer cycle.

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [15:0]       timer_q, timer_d;
    logic [WIDTH-1:0]  fir_sample_q, fir_sample_d;
    logic              fir_valid_q, fir_valid_d;
    logic [OUT_W-1:0]  m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic [15:0]       sample_count_q, sample_count_d;
    logic              push;
    logic              pop;

    // Space is judged on registered occupancy only, so a full FIFO refuses a
    // push even in a cycle where it is also popped.
    assign s_ready = (count_q < FULL_CNT);
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        fir_sample_d   = fir_sample_q;
        fir_valid_d    = 1'b0;
        m_data_d       = m_data_q;
        m_valid_d      = m_valid_q;
        timeout_err_d  = timeout_err_q;
        sample_count_d = sample_count_q;
        if (err_clr) begin
            timeout_err_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    fir_sample_d = mem_q[rd_ptr_q];
                    fir_valid_d  = 1'b1;
                    timer_d      = '0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // A result in the last allowed cycle beats the watchdog.
                if (fir_result_valid) begin
                    m_data_d  = fir_result;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end else if (timer_q >= TMO) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d      = 1'b0;
                    sample_count_d = sample_count_q + 16'd1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            timer_q        <= '0;
            fir_sample_q   <= '0;
            fir_valid_q    <= 1'b0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            timer_q        <= timer_d;
            fir_sample_q   <= fir_sample_d;
            fir_valid_q    <= fir_valid_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            timeout_err_q  <= timeout_err_d;
            sample_count_q <= sample_count_d;
        end
    end

    assign fir_sample   = fir_sample_q;
    assign fir_valid    = fir_valid_q;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign timeout_err  = timeout_err_q;
    assign sample_count = sample_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: a behavioural filter answers each issue after a
// programmable delay; issued samples and expected results are scoreboarded.
module tb_fir_sample_feeder;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;
    localparam int OUT_W   = 2 * WIDTH + 6;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] fir_sample;
    logic             fir_valid;
    logic [OUT_W-1:0] fir_result;
    logic             fir_result_valid;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             timeout_err;
    logic             err_clr = 1'b0;
    logic [15:0]      sample_count;
    logic [1:0]       state_dbg;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [WIDTH-1:0] issue_q[$];

    int               gain = 1;
    int               filt_delay = 3;
    bit               filt_on = 1'b1;
    int               pend = 0;
    logic [OUT_W-1:0] pend_res = '0;
    logic             model_valid = 1'b0;
    logic [OUT_W-1:0] model_data = '0;
    logic             spur_valid = 1'b0;
    logic [OUT_W-1:0] spur_data = '0;
    logic             prev_fv = 1'b0;
    logic [WIDTH-1:0] mon_s;
    logic [OUT_W-1:0] mon_r;

    assign fir_result_valid = model_valid | spur_valid;
    assign fir_result       = spur_valid ? spur_data : model_data;

    fir_sample_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_sample(fir_sample), .fir_valid(fir_valid),
        .fir_result(fir_result), .fir_result_valid(fir_result_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .timeout_err(timeout_err), .err_clr(err_clr),
        .sample_count(sample_count), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] model_res(input logic [WIDTH-1:0] s);
        logic signed [OUT_W-1:0] ext;
        ext = {{(OUT_W - WIDTH){s[WIDTH-1]}}, s};
        return ext * gain;
    endfunction

    // Filter model: answers filt_delay cycles after the issue cycle.
    always @(negedge clk) begin
        model_valid = 1'b0;
        if (!rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    model_valid = 1'b1;
                    model_data  = pend_res;
                end
            end
            if (fir_valid && filt_on) begin
                pend_res = model_res(fir_sample);
                if (filt_delay == 0) begin
                    model_valid = 1'b1;
                    model_data  = pend_res;
                end else begin
                    pend = filt_delay;
                end
            end
        end
    end

    // Scoreboard: issue order, pulse width, result order.
    always @(negedge clk) begin
        if (rst) begin
            if (fir_valid) begin
                checks++;
                if (prev_fv) begin
                    errors++;
                    $display("FAIL fir_valid_width: high 2+ cycles, required 1-cycle pulse");
                end else if (issue_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: fir_sample=%h issued, required no issue", fir_sample);
                end else begin
                    mon_s = issue_q.pop_front();
                    if (fir_sample !== mon_s) begin
                        errors++;
                        $display("FAIL fir_sample: got %h required %h", fir_sample, mon_s);
                    end
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                delivered++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: m_data=%h delivered, required none", m_data);
                end else begin
                    mon_r = exp_q.pop_front();
                    if (m_data !== mon_r) begin
                        errors++;
                        $display("FAIL m_data: got %h required %h", m_data, mon_r);
                    end
                end
            end
        end
        prev_fv = fir_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input bit want);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = s_ready;
            next_cycle();
        end
        s_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_accept: s_ready=0 for 200 cycles, required 1");
        end else begin
            issue_q.push_back(d);
            if (want) exp_q.push_back(model_res(d));
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            next_cycle();
            done = (exp_q.size() == 0) && (issue_q.size() == 0) &&
                   (state_dbg == ST_IDLE) && !m_valid;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: pending results=%0d issues=%0d after 400 cycles, required 0",
                     exp_q.size(), issue_q.size());
        end
    endtask

    task automatic wait_m_valid();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = m_valid;
            next_cycle();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_m_valid: m_valid=0 for 100 cycles, required 1");
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        exp_q.delete();
        issue_q.delete();
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({fir_valid, m_valid, timeout_err, s_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL reset_flags: fv/mv/err/srdy=%b required 0001",
                         {fir_valid, m_valid, timeout_err, s_ready});
            end
            checks++;
            if (fir_sample !== '0 || m_data !== '0 || sample_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_data: fir_sample=%h m_data=%h count=%h required 0",
                         fir_sample, m_data, sample_count);
            end
            if (c == 3) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", state_dbg, ST_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_single();
        logic [OUT_W-1:0] exp_res;
        gain = 1; filt_delay = 3; m_ready = 1'b1;
        exp_res = 38'h00_0000_1234;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                s_valid = 1'b1; s_data = 16'h1234;
                issue_q.push_back(16'h1234);
                exp_q.push_back(model_res(16'h1234));
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (fir_valid !== (c == 2)) begin
                errors++;
                $display("FAIL single_fir_valid: cycle %0d got %b required %b", c, fir_valid, c == 2);
            end
            checks++;
            if (m_valid !== (c == 6)) begin
                errors++;
                $display("FAIL single_m_valid: cycle %0d got %b required %b", c, m_valid, c == 6);
            end
            if (c == 6) begin
                checks++;
                if (m_data !== exp_res) begin
                    errors++;
                    $display("FAIL single_m_data: got %h required %h", m_data, exp_res);
                end
            end
            if (c == 7) begin
                checks++;
                if (sample_count !== 16'd1) begin
                    errors++;
                    $display("FAIL single_count: got %0d required 1", sample_count);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_burst_backpressure();
        logic [WIDTH-1:0] burst [10];
        logic [OUT_W-1:0] exp0;
        int acc, first_block, d0;
        gain = -3; filt_delay = 3; m_ready = 1'b0;
        for (int k = 0; k < 10; k++) burst[k] = 16'($urandom_range(0, 65535));
        exp0 = model_res(burst[0]);
        acc = 0; first_block = -1; d0 = delivered;
        for (int g = 0; g < 300 && acc < 10; g++) begin
            if (g == 11) m_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = burst[acc];
            @(negedge clk);
            if (g >= 6 && g <= 10) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== exp0) begin
                    errors++;
                    $display("FAIL hold_stable: cycle %0d m_valid=%b m_data=%h required 1 %h",
                             g, m_valid, m_data, exp0);
                end
            end
            if (g == 10) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready: s_ready=%b required 0", s_ready);
                end
            end
            if (s_ready) begin
                issue_q.push_back(burst[acc]);
                exp_q.push_back(model_res(burst[acc]));
                acc++;
            end else if (first_block < 0) begin
                first_block = acc;
            end
            next_cycle();
        end
        s_valid = 1'b0;
        checks++;
        if (first_block != 9) begin
            errors++;
            $display("FAIL burst_accepted_before_full: got %0d required 9", first_block);
        end
        wait_drain();
        checks++;
        if (delivered - d0 != 10) begin
            errors++;
            $display("FAIL burst_results: got %0d required 10", delivered - d0);
        end
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] a, b;
        filt_on = 1'b0; m_ready = 1'b1;
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        for (int c = 0; c < 18; c++) begin
            if (c == 0) begin
                s_valid = 1'b1; s_data = a; issue_q.push_back(a);
            end else if (c == 1) begin
                s_valid = 1'b1; s_data = b; issue_q.push_back(b);
            end else begin
                s_valid = 1'b0;
            end
            err_clr = (c == 16);
            @(negedge clk);
            checks++;
            if (fir_valid !== (c == 2 || c == 8)) begin
                errors++;
                $display("FAIL timeout_fir_valid: cycle %0d got %b required %b",
                         c, fir_valid, c == 2 || c == 8);
            end
            checks++;
            if (timeout_err !== (c >= 7 && c <= 16)) begin
                errors++;
                $display("FAIL timeout_err: cycle %0d got %b required %b",
                         c, timeout_err, c >= 7 && c <= 16);
            end
            if (c == 7) begin
                checks++;
                if (state_dbg !== ST_IDLE) begin
                    errors++;
                    $display("FAIL timeout_state: got %0d required %0d", state_dbg, ST_IDLE);
                end
            end
            next_cycle();
        end
        err_clr = 1'b0;
    endtask

    task automatic test_timeout_vs_clear();
        logic [WIDTH-1:0] d;
        d = 16'($urandom_range(0, 65535));
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin
                s_valid = 1'b1; s_data = d; issue_q.push_back(d);
            end else begin
                s_valid = 1'b0;
            end
            err_clr = (c == 6 || c == 8);
            @(negedge clk);
            checks++;
            if (timeout_err !== (c == 7 || c == 8)) begin
                errors++;
                $display("FAIL timeout_vs_clear: cycle %0d got %b required %b",
                         c, timeout_err, c == 7 || c == 8);
            end
            next_cycle();
        end
        err_clr = 1'b0;
        filt_on = 1'b1;
    endtask

    task automatic test_result_at_timeout();
        logic [WIDTH-1:0] d;
        logic [OUT_W-1:0] r;
        gain = 5; filt_delay = TIMEOUT; m_ready = 1'b1;
        d = 16'($urandom_range(32768, 65535));
        r = model_res(d);
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin
                s_valid = 1'b1; s_data = d; issue_q.push_back(d); exp_q.push_back(r);
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (timeout_err !== 1'b0 || m_valid !== (c == 7)) begin
                errors++;
                $display("FAIL edge_result: cycle %0d err=%b m_valid=%b required 0 %b",
                         c, timeout_err, m_valid, c == 7);
            end
            if (c == 7) begin
                checks++;
                if (m_data !== r) begin
                    errors++;
                    $display("FAIL edge_result_data: got %h required %h", m_data, r);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_spurious();
        logic [WIDTH-1:0] d;
        logic [OUT_W-1:0] r;
        for (int c = 0; c < 5; c++) begin
            spur_valid = (c < 4);
            spur_data  = OUT_W'($urandom_range(1, 65535));
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || state_dbg !== ST_IDLE) begin
                errors++;
                $display("FAIL spurious_idle: m_valid=%b state=%0d required 0 %0d",
                         m_valid, state_dbg, ST_IDLE);
            end
            next_cycle();
        end
        gain = 7; filt_delay = 1; m_ready = 1'b0;
        d = 16'($urandom_range(0, 65535));
        r = model_res(d);
        push(d, 1'b1);
        wait_m_valid();
        for (int c = 0; c < 5; c++) begin
            spur_valid = (c < 4);
            spur_data  = ~r;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== r || state_dbg !== ST_HOLD) begin
                errors++;
                $display("FAIL spurious_hold: m_valid=%b m_data=%h state=%0d required 1 %h %0d",
                         m_valid, m_data, state_dbg, r, ST_HOLD);
            end
            next_cycle();
        end
        m_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_count_wrap();
        gain = 1; filt_delay = 2; m_ready = 1'b1;
        force dut.sample_count_q = 16'hFFFE;
        next_cycle();
        release dut.sample_count_q;
        @(negedge clk);
        checks++;
        if (sample_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_preset: got %h required fffe", sample_count);
        end
        next_cycle();
        push(16'($urandom_range(0, 65535)), 1'b1);
        wait_drain();
        checks++;
        if (sample_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_ffff: got %h required ffff", sample_count);
        end
        push(16'($urandom_range(0, 65535)), 1'b1);
        wait_drain();
        checks++;
        if (sample_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap: got %h required 0000", sample_count);
        end
    endtask

    task automatic check_after_reset(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if ({fir_valid, m_valid, timeout_err, s_ready} !== 4'b0001 ||
                state_dbg !== ST_IDLE || m_data !== '0 || sample_count !== 16'd0) begin
                errors++;
                $display("FAIL %s: fv/mv/err/srdy=%b state=%0d m_data=%h count=%h required 0001 0 0 0",
                         tag, {fir_valid, m_valid, timeout_err, s_ready}, state_dbg, m_data,
                         sample_count);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_op();
        logic [WIDTH-1:0] d;
        filt_on = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(16'($urandom_range(0, 65535)), 1'b0);
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_WAIT) begin
            errors++;
            $display("FAIL pre_reset_wait: state=%0d required %0d", state_dbg, ST_WAIT);
        end
        next_cycle();
        pulse_reset();
        check_after_reset("reset_in_wait", 12);

        filt_on = 1'b1; filt_delay = 1; gain = 2; m_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(16'($urandom_range(0, 65535)), 1'b1);
        wait_m_valid();
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_HOLD) begin
            errors++;
            $display("FAIL pre_reset_hold: state=%0d required %0d", state_dbg, ST_HOLD);
        end
        next_cycle();
        pulse_reset();
        check_after_reset("reset_in_hold", 8);

        m_ready = 1'b1;
        d = 16'($urandom_range(0, 65535));
        push(d, 1'b1);
        wait_drain();
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: simulation still running at 500000, required finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_burst_backpressure();
        test_timeout();
        test_timeout_vs_clear();
        test_result_at_timeout();
        test_spurious();
        test_count_wrap();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Upstream-facing driver for the serial FIR filter. Buffers incoming samples in a small FIFO and issues them one at a time on the filter's sample/valid input. It then waits for the filter's output-valid strobe and presents each result on a valid/ready output port. A watchdog flags a filter that never answers. The block sits between the sample source and the FIR filter, closing the loop on the filter's input_valid/output_valid protocol.

## Interface
- WIDTH, 16, sample width; matches the filter's WIDTH
- DEPTH, 8, FIFO entries; power of 2, ≥2
- TIMEOUT, 255, maximum WAIT cycles before the watchdog fires; 1..65535
- OUT_W, 2*WIDTH+6, result width; derived, not overridden

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_data  in  WIDTH  signed upstream sample
- s_valid  in  1  upstream sample valid
- s_ready  out  1  FIFO has space
- fir_sample  out  WIDTH  signed sample to the filter input
- fir_valid  out  1  one-cycle issue strobe to the filter's input_valid
- fir_result  in  OUT_W  signed filter output
- fir_result_valid  in  1  filter output_valid strobe
- m_data  out  OUT_W  signed captured result
- m_valid  out  1  result available
- m_ready  in  1  downstream accepts the result
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err
- sample_count  out  16  completed results delivered; wraps 0xFFFF→0

## Operation
- **FIFO**
  - Push on s_valid && s_ready.
  - s_ready = (occupancy < DEPTH), driven combinationally from registered occupancy.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - A pushed word is poppable from the next cycle.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, WAIT, HOLD.
- **IDLE**
  - If the FIFO is non-empty: pop the head into fir_sample, assert fir_valid, clear the timer, go to WAIT.
  - fir_sample holds its value until the next issue.
- **WAIT**
  - fir_valid is low after the first cycle.
  - If fir_result_valid: capture fir_result into m_data, set m_valid, go to HOLD.
  - Otherwise increment the timer. When the timer reaches TIMEOUT, set timeout_err and go to IDLE; the sample is dropped.
  - A result and a timeout in the same cycle: the result wins.
- **HOLD**
  - m_valid = 1 and m_data is stable.
  - On m_ready: clear m_valid, increment sample_count, go to IDLE.
- **Ignored inputs:** fir_result_valid is ignored in IDLE and HOLD.
- **Error flag:** err_clr clears timeout_err. A timeout set in the same cycle as err_clr wins.
- **Arithmetic:** results are passed through unmodified (signed, full OUT_W). The timer is 16 bits and saturates at TIMEOUT.
- **Reset**
  - Asserting rst at any point flushes the FIFO and abandons any in-flight sample or held result; the state returns to IDLE.
  - Output reset values: fir_valid 0, fir_sample 0, m_valid 0, m_data 0, timeout_err 0, sample_count 0. s_ready reads 1 during reset because the FIFO is empty.

## Timing
- **Push to issue:** push in cycle t → occupancy visible at t+1 → IDLE pops at t+1 → fir_valid high in cycle t+2 only. FIFO-to-filter latency is 2 cycles.
- **First WAIT cycle:** the state is WAIT in the cycle fir_valid is high (cycle i), timer = 0.
  - fir_result_valid is accepted in any cycle from i to i+TIMEOUT.
- **Result capture:** fir_result_valid in cycle r → m_valid and m_data registered at r+1.
- **Handshake:** m_valid && m_ready in cycle h → m_valid low at h+1, state IDLE at h+1. The earliest next fir_valid is h+2.
- **Issue rate:** at most one fir_valid per issue–result–accept cycle. A new fir_valid is never raised while in WAIT or HOLD.
- **Timeout:** no result through cycle i+TIMEOUT → timeout_err high at i+TIMEOUT+1, state IDLE at i+TIMEOUT+1. The next queued sample issues at i+TIMEOUT+2.
- **Output stability:** m_data and m_valid must not change while m_valid && !m_ready.

## Test plan
- **Reset values:** hold rst low, then release → all outputs at reset values; s_ready = 1 throughout.
- **Single sample:** push 0x1234 at cycle 0; model the filter returning 0x00_0000_1234 three cycles after fir_valid; m_ready held high → fir_valid at cycle 2 with fir_sample 0x1234; m_valid at cycle 6 with that data; sample_count = 1 at cycle 7.
- **Burst and backpressure:** push 10 samples back-to-back with DEPTH = 8 → s_ready drops after 8 outstanding entries; all 10 results arrive in order; each fir_valid pulse is exactly one cycle; m_data is stable while m_ready is held low for 5 cycles.
- **Timeout:** TIMEOUT = 4, filter never responds → timeout_err rises 5 cycles after fir_valid; the next queued sample is issued; err_clr then clears the flag. A timeout coinciding with err_clr leaves the flag set.
- **Boundary events:** fir_result_valid arriving in the same cycle the timer hits TIMEOUT → result captured, no error. Spurious fir_result_valid in IDLE or HOLD is ignored. sample_count wraps after 65536 results (force a preset).
- **Reset mid-operation:** assert rst while in WAIT and while in HOLD with 3 queued samples → FIFO empty, m_valid 0, no further fir_valid until new pushes arrive.
